reg_file_reader: RTL and testbench

- Read-side sequencer for the 8-entry register file, the counterpart of the store-driven write sequencer.
- Each rising edge of a user `show` input starts or advances a sweep of read addresses 0..NUM_REGS-1.
- It drives the register file's combinational read port and captures each word into a held output with its index, for LEDs or a seven-segment display.
- In auto mode, one press sweeps all registers, holding each for HOLD_CYCLES.

---
 rtl/reg_file_reader.sv | 141 ++++++++++++++
 tb/tb_reg_file_reader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_reader.sv
// Read-side sequencer for the register file: sweeps read addresses on
// show presses (manual) or on a hold timer (auto), latching each word.
module reg_file_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_REGS    = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  show,
  input  logic                  auto,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic [ADDR_WIDTH-1:0] read_register,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    HOLD
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [ADDR_WIDTH-1:0]   oidx_q, oidx_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    mode_q, mode_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    prev_q, prev_d;

  logic show_edge;
  logic last;
  logic expire;
  logic in_hold;
  logic start;
  logic setup;
  logic abort;
  logic advance;

  assign show_edge = show & ~prev_q;
  assign last      = (idx_q == ADDR_WIDTH'(NUM_REGS - 1));
  assign expire    = (cnt_q == CW'(HOLD_CYCLES - 1));
  assign in_hold   = (state_q == HOLD);
  assign start     = (state_q == IDLE) & show_edge;
  assign setup     = (state_q == SETUP);
  // abort beats timer expiry when both land in the same cycle
  assign abort     = in_hold & mode_q & show_edge;
  assign advance   = in_hold &
                     (mode_q ? (~show_edge & expire) : show_edge);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      oidx_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      prev_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      oidx_q  <= oidx_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   state_d = HOLD;
      HOLD: begin
        if (abort)        state_d = IDLE;
        else if (advance) state_d = last ? IDLE : SETUP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    data_d  = data_q;
    oidx_d  = oidx_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    prev_d  = show;
    unique case (1'b1)
      start: begin
        idx_d  = '0;
        mode_d = auto;
      end
      setup: begin
        data_d  = read_data;
        oidx_d  = idx_q;
        valid_d = 1'b1;
        cnt_d   = '0;
      end
      abort: begin
        idx_d = '0;
      end
      advance: begin
        if (last) begin
          done_d = 1'b1;
          idx_d  = '0;
        end else begin
          idx_d = idx_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        if (in_hold && mode_q) cnt_d = cnt_q + CW'(1);
      end
    endcase
  end

  assign read_register = idx_q;
  assign out_data      = data_q;
  assign out_index     = oidx_q;
  assign out_valid     = valid_q;
  assign done          = done_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_reg_file_reader.sv
// Directed bench for reg_file_reader: manual/auto sweeps, long press,
// abort, asynchronous reset and show held through reset release.
module tb_reg_file_reader;

  logic       clock;
  logic       reset;
  logic       show;
  logic       auto;
  logic [7:0] read_data;
  logic [2:0] read_register;
  logic [7:0] out_data;
  logic [2:0] out_index;
  logic       out_valid;
  logic       busy;
  logic       done;

  int total;
  int passed;

  reg_file_reader dut (
    .clock        (clock),
    .reset        (reset),
    .show         (show),
    .auto         (auto),
    .read_data    (read_data),
    .read_register(read_register),
    .out_data     (out_data),
    .out_index    (out_index),
    .out_valid    (out_valid),
    .busy         (busy),
    .done         (done)
  );

  // register file model: R[i] = 8'h10 + i
  assign read_data = 8'h10 + {5'd0, read_register};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    int n;
    int last;
    int vcnt;
    int got_done;
    total  = 0;
    passed = 0;
    reset  = 1'b0;
    show   = 1'b0;
    auto   = 1'b0;

    // 1: reset and idle
    repeat (3) tick();
    chk("rst_data", out_data, 0);
    chk("rst_index", out_index, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_raddr", read_register, 0);
    reset = 1'b1;
    vcnt = 0;
    repeat (10) begin
      tick();
      if (busy || out_valid) vcnt++;
    end
    chk("idle_quiet", vcnt, 0);

    // 2: manual sweep, 9 presses
    for (int p = 0; p < 9; p++) begin
      show = 1'b1;
      tick();
      if (p == 8) begin
        chk("man_done", done, 1);
        chk("man_end_busy", busy, 0);
        chk("man_end_valid", out_valid, 0);
      end else begin
        chk("man_setup_valid", out_valid, 0);
        chk("man_setup_busy", busy, 1);
      end
      tick();
      if (p < 8) begin
        chk("man_valid", out_valid, 1);
        chk("man_index", out_index, p);
        chk("man_data", out_data, 8'h10 + p);
        chk("man_raddr", read_register, p);
        chk("man_busy", busy, 1);
      end else begin
        chk("man_done_pulse", done, 0);
        chk("man_idle_valid", out_valid, 0);
      end
      tick();
      chk("man_valid_pulse", out_valid, 0);
      show = 1'b0;
      repeat (3) tick();
    end

    // 3: auto sweep; auto drops mid-sweep without effect
    auto = 1'b1;
    show = 1'b1;
    tick();
    show = 1'b0;
    auto = 1'b0;
    n = 0;
    last = 0;
    got_done = 0;
    for (int c = 1; c <= 80; c++) begin
      tick();
      if (out_valid) begin
        if (n == 0) chk("auto_first", c, 1);
        else chk("auto_spacing", c - last, 5);
        chk("auto_index", out_index, n);
        chk("auto_data", out_data, 8'h10 + n);
        last = c;
        n++;
      end
      if (done) begin
        chk("auto_done_lat", c - last, 4);
        chk("auto_done_busy", busy, 0);
        got_done++;
      end
    end
    chk("auto_count", n, 8);
    chk("auto_done_count", got_done, 1);

    // 4: long press in manual mode
    show = 1'b1;
    tick();
    tick();
    chk("long_valid", out_valid, 1);
    chk("long_index", out_index, 0);
    vcnt = 0;
    repeat (48) begin
      tick();
      if (out_valid) vcnt++;
    end
    chk("long_no_adv", vcnt, 0);
    chk("long_busy", busy, 1);
    show = 1'b0;
    tick();
    show = 1'b1;
    tick();
    tick();
    chk("long_next_valid", out_valid, 1);
    chk("long_next_index", out_index, 1);
    show = 1'b0;
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    tick();

    // 5a: abort after third out_valid
    auto = 1'b1;
    show = 1'b1;
    tick();
    show = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      tick();
      if (out_valid) n++;
    end
    chk("abort_seen3", n, 3);
    show = 1'b1;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_index", out_index, 2);
    chk("abort_data", out_data, 8'h12);
    show = 1'b0;
    vcnt = 0;
    repeat (30) begin
      tick();
      if (done || out_valid || busy) vcnt++;
    end
    chk("abort_quiet", vcnt, 0);

    // 5b: async reset mid-HOLD
    show = 1'b1;
    tick();
    show = 1'b0;
    n = 0;
    for (int c = 0; c < 40 && n < 2; c++) begin
      tick();
      if (out_valid) n++;
    end
    chk("arst_seen2", n, 2);
    tick();
    #2 reset = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_data", out_data, 0);
    chk("arst_index", out_index, 0);
    chk("arst_raddr", read_register, 0);
    reset = 1'b1;
    vcnt = 0;
    repeat (25) begin
      tick();
      if (done || out_valid) vcnt++;
    end
    chk("arst_quiet", vcnt, 0);

    // 6: show held high through reset release
    auto = 1'b0;
    show = 1'b1;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    vcnt = 0;
    repeat (3) begin
      tick();
      if (busy || out_valid) vcnt++;
    end
    chk("held_no_sweep", vcnt, 0);
    show = 1'b0;
    tick();
    show = 1'b1;
    tick();
    tick();
    chk("held_valid", out_valid, 1);
    chk("held_index", out_index, 0);
    chk("held_data", out_data, 8'h10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
